// File: rtl/glb_pkg.sv
// ---------------------------------------------------------------------------
// glb_pkg
// Shared definitions for the global-buffer to systolic-array feeder:
//   - GLB_DAT_WIDTH : width of one packed operand word (8 b x 16 rows x 4 banks)
//   - FIFO_DEPTH    : entries in the paired act/wgt return FIFO
//   - glb_state_e   : feeder job FSM states
//   - fifoPtrInc    : modulo-FIFO_DEPTH pointer increment
// ---------------------------------------------------------------------------
package glb_pkg;

  localparam int GLB_DAT_WIDTH  = 512;
  localparam int FIFO_DEPTH     = 3;
  localparam int FIFO_CNT_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } glb_state_e;

  // The FIFO depth is not a power of two, so pointers wrap explicitly.
  function automatic logic [FIFO_CNT_WIDTH-1:0] fifoPtrInc(input logic [FIFO_CNT_WIDTH-1:0] ptr);
    return (ptr == FIFO_CNT_WIDTH'(FIFO_DEPTH - 1)) ? '0 : ptr + FIFO_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/glb_pair_fifo.sv
// ---------------------------------------------------------------------------
// glb_pair_fifo
// Three-entry FIFO holding {activation, weight} word pairs returned from SRAM.
// The head entry is presented combinationally from storage, so a pushed word
// becomes visible the cycle after the push.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_push       : write i_pushData this cycle
//   i_pushData   : {act, wgt} pair
//   i_pop        : consume head entry this cycle
//   i_flush      : synchronous empty (wins over push/pop)
//   o_head       : current head entry
//   o_count      : number of valid entries (0..3)
//   o_empty      : no valid entries
// ---------------------------------------------------------------------------
module glb_pair_fifo
  import glb_pkg::*;
#(
  parameter int WIDTH = 2 * GLB_DAT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_pushData,
  input  logic                      i_pop,
  input  logic                      i_flush,
  output logic [WIDTH-1:0]          o_head,
  output logic [FIFO_CNT_WIDTH-1:0] o_count,
  output logic                      o_empty
);

  logic [WIDTH-1:0]          r_mem [FIFO_DEPTH];
  logic [FIFO_CNT_WIDTH-1:0] r_wrPtr;
  logic [FIFO_CNT_WIDTH-1:0] r_rdPtr;
  logic [FIFO_CNT_WIDTH-1:0] r_count;
  logic                      w_full;
  logic                      w_doPush;
  logic                      w_doPop;

  assign w_full   = (r_count == FIFO_CNT_WIDTH'(FIFO_DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPop  = i_pop && !o_empty;
  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign w_doPush = i_push && (!w_full || w_doPop);

  // Storage, pointers and occupancy; a simultaneous push and pop leaves the
  // count unchanged so the array can be fed one pair per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_pushData;
        r_wrPtr        <= fifoPtrInc(r_wrPtr);
      end
      if (w_doPop) begin
        r_rdPtr <= fifoPtrInc(r_rdPtr);
      end
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + FIFO_CNT_WIDTH'(1);
      end else if (!w_doPush && w_doPop) begin
        r_count <= r_count - FIFO_CNT_WIDTH'(1);
      end
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/glb_sya_feeder.sv
// ---------------------------------------------------------------------------
// glb_sya_feeder
// Streams activation and weight words from global-buffer SRAM into the
// systolic array. One job = CfgTile tiles of CfgChi words each. Activations
// advance linearly; weights replay the same CfgChi words for every tile.
// Reads are throttled so that FIFO occupancy plus the read in flight never
// exceeds the 3-entry return FIFO.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   CCUGLB_Rst                 : synchronous abort/flush
//   CCUGLB_CfgVld/GLBCCU_CfgRdy: job configuration handshake
//   CCUGLB_Cfg*                : act/wgt base address, words per tile, tiles
//   GLBCCU_Done                : one-cycle job-complete pulse
//   Act/WgtRdEn, Act/WgtRdAddr : SRAM reads (data returns one cycle later)
//   Act/WgtRdDat               : SRAM read data
//   GLBSYA_Act/Wgt, *Vld       : operand pair to the array
//   SYAGLB_ActRdy/WgtRdy       : array ready
// ---------------------------------------------------------------------------
module glb_sya_feeder
  import glb_pkg::*;
#(
  parameter int ACT_WIDTH  = 8,
  parameter int NUM_ROW    = 16,
  parameter int NUM_BANK   = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int CHI_WIDTH  = 10
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  CCUGLB_Rst,
  input  logic                                  CCUGLB_CfgVld,
  output logic                                  GLBCCU_CfgRdy,
  input  logic [ADDR_WIDTH-1:0]                 CCUGLB_CfgActBase,
  input  logic [ADDR_WIDTH-1:0]                 CCUGLB_CfgWgtBase,
  input  logic [CHI_WIDTH-1:0]                  CCUGLB_CfgChi,
  input  logic [7:0]                            CCUGLB_CfgTile,
  output logic                                  GLBCCU_Done,
  output logic                                  ActRdEn,
  output logic                                  WgtRdEn,
  output logic [ADDR_WIDTH-1:0]                 ActRdAddr,
  output logic [ADDR_WIDTH-1:0]                 WgtRdAddr,
  input  logic [ACT_WIDTH*NUM_ROW*NUM_BANK-1:0] ActRdDat,
  input  logic [ACT_WIDTH*NUM_ROW*NUM_BANK-1:0] WgtRdDat,
  output logic [ACT_WIDTH*NUM_ROW*NUM_BANK-1:0] GLBSYA_Act,
  output logic [ACT_WIDTH*NUM_ROW*NUM_BANK-1:0] GLBSYA_Wgt,
  output logic                                  GLBSYA_ActVld,
  output logic                                  GLBSYA_WgtVld,
  input  logic                                  SYAGLB_ActRdy,
  input  logic                                  SYAGLB_WgtRdy
);

  localparam int DAT_WIDTH = ACT_WIDTH * NUM_ROW * NUM_BANK;
  localparam int TOT_WIDTH = CHI_WIDTH + 8;

  glb_state_e                r_state;
  glb_state_e                w_nextState;

  logic [CHI_WIDTH-1:0]      r_chi;
  logic [CHI_WIDTH-1:0]      r_chiCnt;
  logic [TOT_WIDTH-1:0]      r_total;
  logic [TOT_WIDTH-1:0]      r_issueCnt;
  logic [TOT_WIDTH-1:0]      w_issueCntInc;
  logic [ADDR_WIDTH-1:0]     r_actPtr;
  logic [ADDR_WIDTH-1:0]     r_wgtPtr;
  logic [ADDR_WIDTH-1:0]     r_wgtBase;
  logic                      r_inflight;

  logic                      w_accept;
  logic                      w_issue;
  logic                      w_roomOk;
  logic                      w_lastIssue;
  logic                      w_tileEnd;
  logic                      w_pop;
  logic                      w_fifoEmpty;
  logic [FIFO_CNT_WIDTH-1:0] w_fifoCnt;
  logic [2*DAT_WIDTH-1:0]    w_fifoHead;

  // The one-cycle SRAM latency means at most one read is ever in flight, so
  // the FIFO can never overflow while this sum stays below its depth.
  assign w_roomOk      = ({1'b0, w_fifoCnt} + {2'b00, r_inflight}) < 3'(FIFO_DEPTH);
  assign w_issueCntInc = r_issueCnt + TOT_WIDTH'(1);
  assign w_lastIssue   = (w_issueCntInc == r_total);
  assign w_tileEnd     = (r_chiCnt == r_chi - CHI_WIDTH'(1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and control outputs. The abort input overrides everything:
  // it blocks config acceptance, read issue and Done, and forces IDLE.
  always_comb begin
    w_nextState   = r_state;
    GLBCCU_CfgRdy = 1'b0;
    GLBCCU_Done   = 1'b0;
    w_accept      = 1'b0;
    w_issue       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        GLBCCU_CfgRdy = 1'b1;
        if (CCUGLB_CfgVld && !CCUGLB_Rst) begin
          w_accept    = 1'b1;
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_total == '0) begin
          w_nextState = ST_DRAIN;
        end else if (w_roomOk) begin
          w_issue = !CCUGLB_Rst;
          if (w_lastIssue) begin
            w_nextState = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_fifoEmpty && !r_inflight) begin
          GLBCCU_Done = !CCUGLB_Rst;
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
    if (CCUGLB_Rst) begin
      w_nextState = ST_IDLE;
    end
  end

  // Job configuration, address pointers and issue bookkeeping. The weight
  // pointer rewinds at the end of every tile; the activation pointer never
  // rewinds. Both wrap naturally at the address width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chi      <= '0;
      r_chiCnt   <= '0;
      r_total    <= '0;
      r_issueCnt <= '0;
      r_actPtr   <= '0;
      r_wgtPtr   <= '0;
      r_wgtBase  <= '0;
      r_inflight <= 1'b0;
    end else if (CCUGLB_Rst) begin
      r_chi      <= '0;
      r_chiCnt   <= '0;
      r_total    <= '0;
      r_issueCnt <= '0;
      r_actPtr   <= '0;
      r_wgtPtr   <= '0;
      r_wgtBase  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_accept) begin
        r_chi      <= CCUGLB_CfgChi;
        r_chiCnt   <= '0;
        r_total    <= {8'd0, CCUGLB_CfgChi} * {{CHI_WIDTH{1'b0}}, CCUGLB_CfgTile};
        r_issueCnt <= '0;
        r_actPtr   <= CCUGLB_CfgActBase;
        r_wgtPtr   <= CCUGLB_CfgWgtBase;
        r_wgtBase  <= CCUGLB_CfgWgtBase;
      end else if (w_issue) begin
        r_issueCnt <= w_issueCntInc;
        r_actPtr   <= r_actPtr + ADDR_WIDTH'(1);
        if (w_tileEnd) begin
          r_chiCnt <= '0;
          r_wgtPtr <= r_wgtBase;
        end else begin
          r_chiCnt <= r_chiCnt + CHI_WIDTH'(1);
          r_wgtPtr <= r_wgtPtr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign ActRdEn   = w_issue;
  assign WgtRdEn   = w_issue;
  assign ActRdAddr = r_actPtr;
  assign WgtRdAddr = r_wgtPtr;

  assign w_pop = !w_fifoEmpty && SYAGLB_ActRdy && SYAGLB_WgtRdy;

  // Both words of a read return together, so one FIFO keeps them paired.
  glb_pair_fifo #(
    .WIDTH (2 * DAT_WIDTH)
  ) u_pairFifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_inflight),
    .i_pushData ({ActRdDat, WgtRdDat}),
    .i_pop      (w_pop),
    .i_flush    (CCUGLB_Rst),
    .o_head     (w_fifoHead),
    .o_count    (w_fifoCnt),
    .o_empty    (w_fifoEmpty)
  );

  assign GLBSYA_Act    = w_fifoHead[2*DAT_WIDTH-1:DAT_WIDTH];
  assign GLBSYA_Wgt    = w_fifoHead[DAT_WIDTH-1:0];
  assign GLBSYA_ActVld = !w_fifoEmpty;
  assign GLBSYA_WgtVld = !w_fifoEmpty;

endmodule

// File: tb/tb_glb_sya_feeder.sv
// ---------------------------------------------------------------------------
// tb_glb_sya_feeder
// Directed bench for glb_sya_feeder. Cycle 0 of a job is the cycle in which
// CfgVld is presented and accepted. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_glb_sya_feeder;

  localparam int AW = 12;
  localparam int CW = 10;
  localparam int DW = 512;

  logic          clk;
  logic          rst_n;
  logic          ccuRst;
  logic          cfgVld;
  logic          cfgRdy;
  logic [AW-1:0] cfgActBase;
  logic [AW-1:0] cfgWgtBase;
  logic [CW-1:0] cfgChi;
  logic [7:0]    cfgTile;
  logic          done;
  logic          actRdEn;
  logic          wgtRdEn;
  logic [AW-1:0] actRdAddr;
  logic [AW-1:0] wgtRdAddr;
  logic [DW-1:0] actRdDat;
  logic [DW-1:0] wgtRdDat;
  logic [DW-1:0] sysAct;
  logic [DW-1:0] sysWgt;
  logic          actVld;
  logic          wgtVld;
  logic          actRdy;
  logic          wgtRdy;

  int checks = 0;
  int errors = 0;

  glb_sya_feeder dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .CCUGLB_Rst        (ccuRst),
    .CCUGLB_CfgVld     (cfgVld),
    .GLBCCU_CfgRdy     (cfgRdy),
    .CCUGLB_CfgActBase (cfgActBase),
    .CCUGLB_CfgWgtBase (cfgWgtBase),
    .CCUGLB_CfgChi     (cfgChi),
    .CCUGLB_CfgTile    (cfgTile),
    .GLBCCU_Done       (done),
    .ActRdEn           (actRdEn),
    .WgtRdEn           (wgtRdEn),
    .ActRdAddr         (actRdAddr),
    .WgtRdAddr         (wgtRdAddr),
    .ActRdDat          (actRdDat),
    .WgtRdDat          (wgtRdDat),
    .GLBSYA_Act        (sysAct),
    .GLBSYA_Wgt        (sysWgt),
    .GLBSYA_ActVld     (actVld),
    .GLBSYA_WgtVld     (wgtVld),
    .SYAGLB_ActRdy     (actRdy),
    .SYAGLB_WgtRdy     (wgtRdy)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM contents are a fixed function of address so expected operands can
  // be derived from expected addresses alone.
  function automatic logic [DW-1:0] actWord(input logic [AW-1:0] a);
    return {8'hA5, {42{a}}};
  endfunction

  function automatic logic [DW-1:0] wgtWord(input logic [AW-1:0] a);
    return {8'h5A, {42{~a}}};
  endfunction

  // SRAM model: data valid exactly one cycle after the read enable.
  always @(posedge clk) begin
    actRdDat <= actRdEn ? actWord(actRdAddr) : '0;
    wgtRdDat <= wgtRdEn ? wgtWord(wgtRdAddr) : '0;
  end

  task automatic applyStimulus(input logic [AW-1:0] aBase, input logic [AW-1:0] wBase,
                               input logic [CW-1:0] chi, input logic [7:0] tile);
    cfgActBase = aBase;
    cfgWgtBase = wBase;
    cfgChi     = chi;
    cfgTile    = tile;
    cfgVld     = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cfgRdy !== 1'b1 || done !== 1'b0 || actRdEn !== 1'b0 || wgtRdEn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: cfgRdy=%b done=%b rdEn=%b/%b, expected 1 0 0/0",
               cfgRdy, done, actRdEn, wgtRdEn);
    end
    checks++;
    if (actRdAddr !== '0 || wgtRdAddr !== '0 || actVld !== 1'b0 || wgtVld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_addr_vld: addr=%h/%h vld=%b/%b, expected 0/0 0/0",
               actRdAddr, wgtRdAddr, actVld, wgtVld);
    end
    checks++;
    if (sysAct !== '0 || sysWgt !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: act[31:0]=%h wgt[31:0]=%h, expected 0", sysAct[31:0], sysWgt[31:0]);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int issued  = 0;
    int popped  = 0;
    int doneCyc = -1;
    logic [AW-1:0] eAct;
    logic [AW-1:0] eWgt;
    applyStimulus(12'h010, 12'h080, 10'd4, 8'd2);
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      if (c == 0 || c == 1 || c == 11 || c == 12) begin
        checks++;
        if (cfgRdy !== ((c == 0 || c == 12) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("[TB] FAIL basic_cfgrdy: cycle %0d cfgRdy=%b", c, cfgRdy);
        end
      end
      if (actRdEn || wgtRdEn) begin
        eAct = 12'(12'h010 + issued);
        eWgt = 12'(12'h080 + (issued % 4));
        checks++;
        if (c != 1 + issued || actRdEn !== 1'b1 || wgtRdEn !== 1'b1 || actRdAddr !== eAct || wgtRdAddr !== eWgt) begin
          errors++;
          $display("[TB] FAIL basic_issue: cycle %0d en=%b/%b act=%h wgt=%h, expected cycle %0d act=%h wgt=%h",
                   c, actRdEn, wgtRdEn, actRdAddr, wgtRdAddr, 1 + issued, eAct, eWgt);
        end
        issued++;
      end
      if (actVld || wgtVld) begin
        eAct = 12'(12'h010 + popped);
        eWgt = 12'(12'h080 + (popped % 4));
        checks++;
        if (c != 3 + popped || actVld !== wgtVld || sysAct !== actWord(eAct) || sysWgt !== wgtWord(eWgt)) begin
          errors++;
          $display("[TB] FAIL basic_pair: cycle %0d vld=%b/%b act[15:0]=%h wgt[15:0]=%h, expected cycle %0d addr %h/%h",
                   c, actVld, wgtVld, sysAct[15:0], sysWgt[15:0], 3 + popped, eAct, eWgt);
        end
        popped++;
      end
      if (done) begin
        checks++;
        if (doneCyc >= 0 || c != 11) begin
          errors++;
          $display("[TB] FAIL basic_done_cycle: done at cycle %0d, expected single pulse at 11", c);
        end
        doneCyc = c;
      end
      @(posedge clk);
      #1;
      cfgVld = 1'b0;
    end
    checks++;
    if (issued != 8 || popped != 8 || doneCyc != 11) begin
      errors++;
      $display("[TB] FAIL basic_totals: issued=%0d popped=%0d done=%0d, expected 8 8 11", issued, popped, doneCyc);
    end
  endtask

  task automatic test_backpressure();
    int issued  = 0;
    int popped  = 0;
    int doneCyc = -1;
    logic prevStall = 1'b0;
    logic [DW-1:0] prevAct = '0;
    logic [DW-1:0] prevWgt = '0;
    logic [AW-1:0] eAct;
    applyStimulus(12'h010, 12'h080, 10'd4, 8'd2);
    for (int c = 0; c < 40 && doneCyc < 0; c++) begin
      actRdy = !(c >= 4 && c <= 9);
      wgtRdy = actRdy;
      @(negedge clk);
      if (prevStall) begin
        checks++;
        if (actVld !== 1'b1 || sysAct !== prevAct || sysWgt !== prevWgt) begin
          errors++;
          $display("[TB] FAIL bp_hold: cycle %0d vld=%b act[15:0]=%h, expected held %h",
                   c, actVld, sysAct[15:0], prevAct[15:0]);
        end
      end
      if (actRdEn) issued++;
      checks++;
      if (issued - popped > 3) begin
        errors++;
        $display("[TB] FAIL bp_outstanding: cycle %0d outstanding=%0d, expected <= 3", c, issued - popped);
      end
      if (actVld && actRdy) begin
        eAct = 12'(12'h010 + popped);
        checks++;
        if (sysAct !== actWord(eAct) || sysWgt !== wgtWord(12'(12'h080 + (popped % 4)))) begin
          errors++;
          $display("[TB] FAIL bp_order: pop %0d act[15:0]=%h wgt[15:0]=%h, expected act addr %h",
                   popped, sysAct[15:0], sysWgt[15:0], eAct);
        end
        popped++;
      end
      prevStall = actVld && !actRdy;
      prevAct   = sysAct;
      prevWgt   = sysWgt;
      if (done) doneCyc = c;
      @(posedge clk);
      #1;
      cfgVld = 1'b0;
    end
    actRdy = 1'b1;
    wgtRdy = 1'b1;
    checks++;
    if (issued != 8 || popped != 8 || doneCyc < 0) begin
      errors++;
      $display("[TB] FAIL bp_totals: issued=%0d popped=%0d done=%0d, expected 8 8 and done seen",
               issued, popped, doneCyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] eAct [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    logic [AW-1:0] eWgt [4] = '{12'hFFD, 12'hFFE, 12'hFFF, 12'h000};
    int issued  = 0;
    int popped  = 0;
    int doneCyc = -1;
    applyStimulus(12'hFFE, 12'hFFD, 10'd4, 8'd1);
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (actRdEn && issued < 4) begin
        checks++;
        if (actRdAddr !== eAct[issued] || wgtRdAddr !== eWgt[issued]) begin
          errors++;
          $display("[TB] FAIL wrap_addr: issue %0d act=%h wgt=%h, expected %h %h",
                   issued, actRdAddr, wgtRdAddr, eAct[issued], eWgt[issued]);
        end
        issued++;
      end else if (actRdEn) begin
        issued++;
      end
      if (actVld && popped < 4) begin
        checks++;
        if (sysAct !== actWord(eAct[popped]) || sysWgt !== wgtWord(eWgt[popped])) begin
          errors++;
          $display("[TB] FAIL wrap_pair: pop %0d act[15:0]=%h, expected addr %h", popped, sysAct[15:0], eAct[popped]);
        end
        popped++;
      end
      if (done) doneCyc = c;
      @(posedge clk);
      #1;
      cfgVld = 1'b0;
    end
    checks++;
    if (issued != 4 || popped != 4 || doneCyc != 7) begin
      errors++;
      $display("[TB] FAIL wrap_totals: issued=%0d popped=%0d done=%0d, expected 4 4 7", issued, popped, doneCyc);
    end
  endtask

  task automatic test_empty_job();
    int reads = 0;
    int vlds  = 0;
    int doneCyc = -1;
    applyStimulus(12'h100, 12'h200, 10'd0, 8'd5);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (actRdEn || wgtRdEn) reads++;
      if (actVld || wgtVld) vlds++;
      if (done) doneCyc = (doneCyc < 0) ? c : 99;
      if (c >= 1 && c <= 3) begin
        checks++;
        if (cfgRdy !== ((c == 3) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("[TB] FAIL empty_cfgrdy: cycle %0d cfgRdy=%b", c, cfgRdy);
        end
      end
      @(posedge clk);
      #1;
      cfgVld = 1'b0;
    end
    checks++;
    if (reads != 0 || vlds != 0 || doneCyc != 2) begin
      errors++;
      $display("[TB] FAIL empty_job: reads=%0d vldCycles=%0d done=%0d, expected 0 0 2", reads, vlds, doneCyc);
    end
  endtask

  task automatic test_abort();
    int issued  = 0;
    int popped  = 0;
    int doneCyc = -1;
    int earlyDone = 0;
    applyStimulus(12'h010, 12'h080, 10'd4, 8'd2);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (done) earlyDone++;
      @(posedge clk);
      #1;
      cfgVld = 1'b0;
      if (c == 4) ccuRst = 1'b1;
    end
    ccuRst = 1'b0;
    applyStimulus(12'h020, 12'h040, 10'd2, 8'd1);
    for (int r = 0; r <= 7; r++) begin
      @(negedge clk);
      if (r == 0) begin
        checks++;
        if (cfgRdy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL abort_cfgrdy: cfgRdy=%b at cycle 6, expected 1", cfgRdy);
        end
      end
      if (r <= 2) begin
        checks++;
        if (actVld !== 1'b0 || wgtVld !== 1'b0) begin
          errors++;
          $display("[TB] FAIL abort_vld_low: cycle %0d vld=%b/%b, expected 0", 6 + r, actVld, wgtVld);
        end
      end
      if (actRdEn) begin
        checks++;
        if (r != 1 + issued || actRdAddr !== 12'(12'h020 + issued) || wgtRdAddr !== 12'(12'h040 + issued)) begin
          errors++;
          $display("[TB] FAIL abort_new_issue: rel %0d act=%h wgt=%h, expected rel %0d", r, actRdAddr, wgtRdAddr, 1 + issued);
        end
        issued++;
      end
      if (actVld) begin
        checks++;
        if (r != 3 + popped || sysAct !== actWord(12'(12'h020 + popped)) || sysWgt !== wgtWord(12'(12'h040 + popped))) begin
          errors++;
          $display("[TB] FAIL abort_new_pair: rel %0d act[15:0]=%h, expected rel %0d", r, sysAct[15:0], 3 + popped);
        end
        popped++;
      end
      if (done) doneCyc = (doneCyc < 0) ? r : 99;
      @(posedge clk);
      #1;
      cfgVld = 1'b0;
    end
    checks++;
    if (earlyDone != 0 || issued != 2 || popped != 2 || doneCyc != 5) begin
      errors++;
      $display("[TB] FAIL abort_totals: abortDone=%0d issued=%0d popped=%0d done=%0d, expected 0 2 2 5",
               earlyDone, issued, popped, doneCyc);
    end
  endtask

  initial begin
    ccuRst     = 1'b0;
    cfgVld     = 1'b0;
    cfgActBase = '0;
    cfgWgtBase = '0;
    cfgChi     = '0;
    cfgTile    = '0;
    actRdy     = 1'b1;
    wgtRdy     = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_empty_job();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
